// File: rtl/riscv_pkg.sv
// Shared RV32 definitions: register-file geometry, M-extension funct3 codes
// and the multiply/divide sequencer state type.
package riscv_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } muldiv_state_t;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit, one bit per cycle, driving the
// register-file write port for a single cycle when the result is ready.
module muldiv_unit
    import riscv_pkg::*;
#(
    parameter int WIDTH  = XLEN,
    parameter int ADDR_W = REG_ADDR_W
) (
    input  logic              clk,
    input  logic              clear,
    input  logic              start,
    input  logic [2:0]        funct3,
    input  logic [WIDTH-1:0]  rs1_val,
    input  logic [WIDTH-1:0]  rs2_val,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              busy,
    output logic              done,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [WIDTH-1:0]  wr_data
);

    muldiv_state_t      state;
    logic [4:0]         cnt;
    logic [2:0]         op;
    logic [ADDR_W-1:0]  rd_q;
    logic [WIDTH-1:0]   opb;
    logic [2*WIDTH-1:0] acc;
    logic               neg_q;
    logic               neg_r;
    logic               bypass;

    logic               is_div, s1, s2, div0, ovf;
    logic [WIDTH-1:0]   mag1, mag2, spec_res;
    logic [WIDTH:0]     mul_sum, div_r;
    logic [WIDTH-1:0]   div_sub;
    logic               div_ge;
    logic [2*WIDTH-1:0] mul_next, div_next, prod_s;
    logic [WIDTH-1:0]   result;

    // Operand conditioning at launch: magnitudes, result signs, no-iteration cases.
    always_comb begin
        is_div = funct3[2];
        s1 = rs1_val[WIDTH-1] && (funct3 == F3_MULH || funct3 == F3_MULHSU ||
                                  funct3 == F3_DIV  || funct3 == F3_REM);
        s2 = rs2_val[WIDTH-1] && (funct3 == F3_MULH || funct3 == F3_DIV ||
                                  funct3 == F3_REM);
        mag1 = s1 ? -rs1_val : rs1_val;
        mag2 = s2 ? -rs2_val : rs2_val;
        div0 = is_div && (rs2_val == '0);
        ovf  = (funct3 == F3_DIV || funct3 == F3_REM) &&
               (rs1_val == {1'b1, {(WIDTH-1){1'b0}}}) && (rs2_val == '1);
        spec_res = '0;
        if (div0)
            spec_res = funct3[1] ? rs1_val : '1;
        else if (ovf)
            spec_res = funct3[1] ? '0 : {1'b1, {(WIDTH-1){1'b0}}};
    end

    // acc is {hi, multiplier} for multiply and {remainder, dividend/quotient} for divide.
    always_comb begin
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opb : '0)};
        mul_next = {mul_sum, acc[WIDTH-1:1]};
        div_r    = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_ge   = div_r >= {1'b0, opb};
        div_sub  = div_r[WIDTH-1:0] - opb;
        div_next = {(div_ge ? div_sub : div_r[WIDTH-1:0]), acc[WIDTH-2:0], div_ge};
    end

    always_comb begin
        prod_s = neg_q ? -acc : acc;
        result = '0;
        if (bypass)
            result = acc[WIDTH-1:0];
        else begin
            case (op)
                F3_MUL:                      result = prod_s[WIDTH-1:0];
                F3_MULH, F3_MULHSU, F3_MULHU: result = prod_s[2*WIDTH-1:WIDTH];
                F3_DIV, F3_DIVU:             result = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
                default:                     result = neg_r ? -acc[2*WIDTH-1:WIDTH]
                                                            : acc[2*WIDTH-1:WIDTH];
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            state   <= IDLE;
            cnt     <= '0;
            op      <= '0;
            rd_q    <= '0;
            opb     <= '0;
            acc     <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            bypass  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op    <= funct3;
                        rd_q  <= rd_addr;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        neg_q <= s1 ^ s2;
                        neg_r <= s1;
                        if (div0 || ovf) begin
                            bypass <= 1'b1;
                            acc    <= {{WIDTH{1'b0}}, spec_res};
                            state  <= DONE;
                        end else begin
                            bypass <= 1'b0;
                            acc    <= {{WIDTH{1'b0}}, (is_div ? mag1 : mag2)};
                            opb    <= is_div ? mag2 : mag1;
                            state  <= CALC;
                        end
                    end
                end
                CALC: begin
                    acc <= op[2] ? div_next : mul_next;
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31)
                        state <= DONE;
                end
                DONE: begin
                    // First DONE cycle registers the result; second retires the pulse.
                    if (!done) begin
                        done    <= 1'b1;
                        wr_en   <= (rd_q != '0);
                        wr_addr <= rd_q;
                        wr_data <= result;
                    end else begin
                        done  <= 1'b0;
                        wr_en <= 1'b0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed RV32M cases plus random
// operations compared against a plain-arithmetic reference.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        clear;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [4:0]  rd_addr;
    logic        busy;
    logic        done;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;

    int    n_checks = 0;
    int    n_fail   = 0;
    string cur      = "";

    muldiv_unit #(.WIDTH(32), .ADDR_W(5)) dut (
        .clk     (clk),
        .clear   (clear),
        .start   (start),
        .funct3  (funct3),
        .rs1_val (rs1_val),
        .rs2_val (rs2_val),
        .rd_addr (rd_addr),
        .busy    (busy),
        .done    (done),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s [%s]: got %0h expected %0h", tag, cur, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a,
                                               input logic [31:0] b);
        longint      sa, sb, ub;
        logic [63:0] p;
        int          ia, ib, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = longint'({32'd0, b});
        ia = $signed(a);
        ib = $signed(b);
        case (f)
            3'd0: begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
            3'd1: begin p = 64'(sa * sb); return p[63:32]; end
            3'd2: begin p = 64'(sa * ub); return p[63:32]; end
            3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                r = ia / ib; return 32'(r);
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                r = ia % ib; return 32'(r);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic bit is_special(input logic [2:0] f, input logic [31:0] a,
                                      input logic [31:0] b);
        if (!f[2]) return 1'b0;
        if (b == 0) return 1'b1;
        return (f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
    endfunction

    // Called at a negedge with the DUT idle; returns at the negedge after done falls.
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input bit inject);
        logic [31:0] exp;
        int          exp_lat, lat, busy_n;
        bit          early_wr;
        exp     = ref_result(f, a, b);
        exp_lat = is_special(f, a, b) ? 1 : 33;
        cur     = $sformatf("f3=%0d a=%h b=%h rd=%0d", f, a, b, rd);
        funct3  = f; rs1_val = a; rs2_val = b; rd_addr = rd; start = 1'b1;
        @(negedge clk);
        start = 1'b0; lat = 0; busy_n = 0; early_wr = 1'b0;
        while (!done && lat < 100) begin
            if (busy) busy_n++;
            if (wr_en) early_wr = 1'b1;
            if (inject && lat == 10) begin
                start = 1'b1; funct3 = ~f; rs1_val = ~a; rs2_val = a; rd_addr = ~rd;
            end else
                start = 1'b0;
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        if (busy) busy_n++;
        check("latency",  64'(lat), 64'(exp_lat));
        check("busy_len", 64'(busy_n), 64'(exp_lat + 1));
        check("early_wr", 64'(early_wr), 64'd0);
        check("wr_data",  64'(wr_data), 64'(exp));
        check("wr_addr",  64'(wr_addr), 64'(rd));
        check("wr_en",    64'(wr_en), 64'(rd != 5'd0));
        @(negedge clk);
        check("done_fall", 64'(done), 64'd0);
        check("busy_fall", 64'(busy), 64'd0);
        check("wr_en_fall", 64'(wr_en), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bit          saw_wr;
        logic [2:0]  rf;
        logic [31:0] ra, rb;
        clear = 1'b1; start = 1'b0; funct3 = '0; rs1_val = '0; rs2_val = '0; rd_addr = '0;
        repeat (2) @(negedge clk);
        cur = "reset";
        check("rst_busy",  64'(busy), 64'd0);
        check("rst_done",  64'(done), 64'd0);
        check("rst_wr_en", 64'(wr_en), 64'd0);
        check("rst_wdata", 64'(wr_data), 64'd0);
        check("rst_waddr", 64'(wr_addr), 64'd0);
        // clear wins over start
        start = 1'b1; funct3 = 3'd0; rs1_val = 32'd3; rs2_val = 32'd3; rd_addr = 5'd1;
        @(negedge clk);
        start = 1'b0; clear = 1'b0;
        check("clr_prio_busy", 64'(busy), 64'd0);

        run_op(3'd0, 32'd7,         32'hFFFF_FFFD, 5'd5,  1'b0);
        run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd6,  1'b0);
        run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7,  1'b0);
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8,  1'b0);
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2,         5'd9,  1'b0);
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2,         5'd10, 1'b0);
        run_op(3'd5, 32'd100,       32'd7,         5'd11, 1'b0);
        run_op(3'd7, 32'd100,       32'd7,         5'd12, 1'b0);
        run_op(3'd4, 32'd5,         32'd0,         5'd13, 1'b0);
        run_op(3'd7, 32'd5,         32'd0,         5'd14, 1'b0);
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 1'b0);
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 1'b0);
        run_op(3'd4, 32'd1234567,   32'hFFFF_FFF0, 5'd17, 1'b1);
        run_op(3'd0, 32'd9,         32'd9,         5'd0,  1'b0);
        // back-to-back: second start lands in the first idle cycle
        run_op(3'd5, 32'hDEAD_BEEF, 32'd1000,      5'd20, 1'b0);
        run_op(3'd3, 32'hDEAD_BEEF, 32'hCAFE_F00D, 5'd21, 1'b0);

        // clear while iterating at counter 10
        cur = "clear_mid_calc";
        funct3 = 3'd0; rs1_val = 32'd11; rs2_val = 32'd13; rd_addr = 5'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("clr_busy", 64'(busy), 64'd0);
        saw_wr = 1'b0;
        repeat (40) begin
            if (wr_en || done) saw_wr = 1'b1;
            @(negedge clk);
        end
        check("clr_no_wr", 64'(saw_wr), 64'd0);

        for (int i = 0; i < 40; i++) begin
            rf = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: rb = 32'($urandom_range(1, 20));
                2: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                3: ra = 32'($urandom_range(0, 1000));
                default: ;
            endcase
            run_op(rf, ra, rb, 5'($urandom_range(0, 31)), 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
